// File: rtl/dag_circ_agen.sv
// dag_circ_agen: circular-buffer address generator for the DSP DAG.
// Holds NREG index/modify/length register sets. Each request issues the
// current index and post-modifies it, wrapping inside the circular buffer
// derived from I and L (L == 0 selects plain linear addressing).
// Optional feature macro: DAG_BITREV_EN (bit-reversed issue, linear update).
module dag_circ_agen #(
  parameter  int AW   = 14,
  parameter  int NREG = 4,
  localparam int IW   = $clog2(NREG)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic          wr_en,
  input  logic [1:0]    wr_sel,
  input  logic [IW-1:0] wr_idx,
  input  logic [AW-1:0] wr_data,
  input  logic          req_valid,
  input  logic [IW-1:0] req_idx,
  input  logic          req_brev,
  output logic [AW-1:0] addr_out,
  output logic          addr_valid,
  input  logic [IW-1:0] rd_idx,
  output logic [AW-1:0] rd_i
);

  logic [AW-1:0] i_reg [NREG];
  logic [AW-1:0] m_reg [NREG];
  logic [AW-1:0] l_reg [NREG];

  logic [AW-1:0]        cur_i, cur_m, cur_l;
  logic [AW-1:0]        smear, mask, base;
  logic                 l_pow2;
  logic signed [AW+1:0] t_sum, t_up, t_dn, lim, base_x, l_x;
  logic [AW-1:0]        nxt_i, issue_addr;

  assign rd_i = i_reg[rd_idx];

  // Mask decode, modify add, single wrap correction for the requested set.
  always_comb begin
    cur_i = i_reg[req_idx];
    cur_m = m_reg[req_idx];
    cur_l = l_reg[req_idx];
    // smear fills every bit below the MSB of L: 2^(msb+1)-1
    smear = cur_l;
    for (int s = 1; s < AW; s = s * 2) begin
      smear = smear | (smear >> s);
    end
    l_pow2 = ((cur_l & (cur_l - 1'b1)) == '0);
    mask   = l_pow2 ? (cur_l - 1'b1) : smear;
    base   = cur_i & ~mask;
    // two guard bits keep negative sums distinguishable from large ones
    t_sum  = $signed({2'b00, cur_i}) + $signed({{2{cur_m[AW-1]}}, cur_m});
    base_x = $signed({2'b00, base});
    l_x    = $signed({2'b00, cur_l});
    lim    = base_x + l_x;
    t_up   = t_sum - l_x;
    t_dn   = t_sum + l_x;
    nxt_i  = t_sum[AW-1:0];
    if (cur_l != '0) begin
      if (!cur_m[AW-1] && (t_sum >= lim)) begin
        nxt_i = t_up[AW-1:0];
      end else if (cur_m[AW-1] && (t_sum < base_x)) begin
        nxt_i = t_dn[AW-1:0];
      end
    end
    issue_addr = cur_i;
`ifdef DAG_BITREV_EN
    if (req_brev) begin
      for (int b = 0; b < AW; b++) begin
        issue_addr[b] = cur_i[AW-1-b];
      end
      nxt_i = t_sum[AW-1:0];
    end
`endif
  end

`ifndef DAG_BITREV_EN
  logic unused_req_brev;
  assign unused_req_brev = req_brev;
`endif

  // Register file, request writeback and issue; host I write wins over writeback.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int k = 0; k < NREG; k++) begin
        i_reg[k] <= '0;
        m_reg[k] <= '0;
        l_reg[k] <= '0;
      end
      addr_out   <= '0;
      addr_valid <= 1'b0;
    end else begin
      addr_valid <= req_valid;
      if (req_valid) begin
        addr_out       <= issue_addr;
        i_reg[req_idx] <= nxt_i;
      end
      if (wr_en) begin
        case (wr_sel)
          2'd0:    i_reg[wr_idx] <= wr_data;
          2'd1:    m_reg[wr_idx] <= wr_data;
          2'd2:    l_reg[wr_idx] <= wr_data;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_dag_circ_agen.sv
// Directed bench for dag_circ_agen (AW=14, NREG=4).
module tb_dag_circ_agen;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        wr_en;
  logic [1:0]  wr_sel;
  logic [1:0]  wr_idx;
  logic [13:0] wr_data;
  logic        req_valid;
  logic [1:0]  req_idx;
  logic        req_brev;
  logic [13:0] addr_out;
  logic        addr_valid;
  logic [1:0]  rd_idx;
  logic [13:0] rd_i;

  int n_run  = 0;
  int n_fail = 0;

  dag_circ_agen #(.AW(14), .NREG(4)) dut (
    .CLK(CLK), .RST_N(RST_N),
    .wr_en(wr_en), .wr_sel(wr_sel), .wr_idx(wr_idx), .wr_data(wr_data),
    .req_valid(req_valid), .req_idx(req_idx), .req_brev(req_brev),
    .addr_out(addr_out), .addr_valid(addr_valid),
    .rd_idx(rd_idx), .rd_i(rd_i)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_run++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic wr(input logic [1:0] sel, input logic [1:0] idx, input logic [13:0] d);
    wr_en = 1'b1; wr_sel = sel; wr_idx = idx; wr_data = d;
    @(posedge CLK); #1;
    wr_en = 1'b0;
  endtask

  task automatic req(input logic [1:0] idx);
    req_valid = 1'b1; req_idx = idx; rd_idx = idx;
    @(posedge CLK); #1;
    req_valid = 1'b0;
  endtask

  task automatic load(input logic [1:0] idx, input logic [13:0] i_v,
                      input logic [13:0] m_v, input logic [13:0] l_v);
    wr(2'd0, idx, i_v);
    wr(2'd1, idx, m_v);
    wr(2'd2, idx, l_v);
  endtask

  initial begin
    RST_N = 1'b0; wr_en = 1'b0; wr_sel = '0; wr_idx = '0; wr_data = '0;
    req_valid = 1'b0; req_idx = '0; req_brev = 1'b0; rd_idx = '0;
    #23;
    chk("rst_addr_out", addr_out, 0);
    chk("rst_addr_valid", addr_valid, 0);
    for (int k = 0; k < 4; k++) begin
      rd_idx = 2'(k); #1;
      chk($sformatf("rst_rd_i%0d", k), rd_i, 0);
    end
    RST_N = 1'b1;
    #1;

    // non-power-of-two wrap up then down
    load(2'd1, 14'h0108, 14'd3, 14'd10);
    req(2'd1);
    chk("np2_up_addr", addr_out, 14'h0108);
    chk("np2_up_valid", addr_valid, 1);
    chk("np2_up_i", rd_i, 14'h0101);
    wr(2'd1, 2'd1, 14'h3FFD);
    chk("valid_drop", addr_valid, 0);
    req(2'd1);
    chk("np2_dn_addr", addr_out, 14'h0101);
    chk("np2_dn_i", rd_i, 14'h0108);

    // power-of-two wrap
    load(2'd2, 14'h0206, 14'd4, 14'd8);
    req(2'd2);
    chk("p2_addr", addr_out, 14'h0206);
    chk("p2_i", rd_i, 14'h0202);

    // linear rollover
    load(2'd3, 14'h3FFF, 14'd1, 14'd0);
    req(2'd3);
    chk("lin_addr", addr_out, 14'h3FFF);
    chk("lin_i", rd_i, 14'h0000);

    // same-edge host I write overrides writeback
    wr_en = 1'b1; wr_sel = 2'd0; wr_idx = 2'd3; wr_data = 14'h0055;
    req(2'd3);
    wr_en = 1'b0;
    chk("conf_i_addr", addr_out, 14'h0000);
    chk("conf_i_i", rd_i, 14'h0055);

    // same-edge M write applies from the next request
    load(2'd0, 14'd0, 14'd1, 14'd4);
    wr_en = 1'b1; wr_sel = 2'd1; wr_idx = 2'd0; wr_data = 14'd2;
    req(2'd0);
    wr_en = 1'b0;
    chk("conf_m_addr", addr_out, 0);
    chk("conf_m_i", rd_i, 1);
    req(2'd0);
    chk("conf_m_addr2", addr_out, 1);
    chk("conf_m_i2", rd_i, 3);

    // back-to-back requests, L=4 M=1 from I=0
    load(2'd0, 14'd0, 14'd1, 14'd4);
    req_valid = 1'b1; req_idx = 2'd0; rd_idx = 2'd0;
    for (int k = 0; k < 4; k++) begin
      @(posedge CLK); #1;
      chk($sformatf("b2b_addr%0d", k), addr_out, 32'(k));
      chk($sformatf("b2b_valid%0d", k), addr_valid, 1);
    end
    req_valid = 1'b0;
    chk("b2b_i", rd_i, 0);

    // reserved select is ignored
    wr(2'd3, 2'd0, 14'h1234);
    rd_idx = 2'd0; #1;
    chk("rsvd_i", rd_i, 0);

    // bit-reverse request (normal issue when the feature is not built)
    load(2'd0, 14'h0001, 14'd1, 14'd4);
    req_brev = 1'b1;
    req(2'd0);
    req_brev = 1'b0;
`ifdef DAG_BITREV_EN
    chk("brev_addr", addr_out, 14'h2000);
`else
    chk("brev_addr", addr_out, 14'h0001);
`endif
    chk("brev_i", rd_i, 14'h0002);

    // reset asserted mid-stream
    req_valid = 1'b1; req_idx = 2'd1;
    @(posedge CLK); #1;
    chk("mid_valid_pre", addr_valid, 1);
    RST_N = 1'b0; #1;
    req_valid = 1'b0;
    chk("mid_valid", addr_valid, 0);
    chk("mid_addr", addr_out, 0);
    for (int k = 0; k < 4; k++) begin
      rd_idx = 2'(k); #1;
      chk($sformatf("mid_rd_i%0d", k), rd_i, 0);
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    chk("post_rst_valid", addr_valid, 0);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
